// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the MM:SS stopwatch.
// Holds the BCD digit type, seven-segment codes, anode indices and a mod-60 BCD helper.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp stays off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] AN_SEC_ONES = 2'd0;
  localparam logic [1:0] AN_SEC_TENS = 2'd1;
  localparam logic [1:0] AN_MIN_ONES = 2'd2;
  localparam logic [1:0] AN_MIN_TENS = 2'd3;

  function automatic logic [7:0] seg_encode(input bcd_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // {tens, ones} BCD pair incremented modulo 60
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd9)      r = {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: board-facing pins of the stopwatch (switches, button, display drives).
// The slave modport is the stopwatch side; master is the board/bench side.
interface stopwatch_if;
  logic       adj;
  logic       sel;
  logic       pause;
  logic [7:0] seg;
  logic [3:0] an;

  modport master (output adj, sel, pause, input seg, an);
  modport slave  (input adj, sel, pause, output seg, an);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability counter; emits a one-cycle pulse
// when the input has been high-stable for DEBOUNCE_CYCLES samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_meta;
  logic          sync_q;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      rise      <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      rise      <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync_q;
        rise   <= sync_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_top_level.sv
// stopwatch_top_level: MM:SS stopwatch with pause/resume, 2 Hz field adjust and a
// multiplexed 4-digit display. Define STOPWATCH_BLINK_EN to blink the adjusted field.
module stopwatch_top_level
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int SCAN_CYCLES     = 100_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  stopwatch_if.slave pins
);
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int SW = $clog2(SCAN_CYCLES + 1);

  logic          adj_meta, adj_s, sel_meta, sel_s;
  logic          press, running;
  logic [PW-1:0] sec_pre, adj_pre;
  logic          sec_tick, adj_tick;
  bcd_t          min_tens, min_ones, sec_tens, sec_ones;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  bcd_t          cur_digit;
  logic          blank;
  logic [7:0]    seg_q;
  logic [3:0]    an_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk  (clk),
    .rst  (rst),
    .btn  (pins.pause),
    .rise (press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adj_meta <= 1'b0;
      adj_s    <= 1'b0;
      sel_meta <= 1'b0;
      sel_s    <= 1'b0;
    end else begin
      adj_meta <= pins.adj;
      adj_s    <= adj_meta;
      sel_meta <= pins.sel;
      sel_s    <= sel_meta;
    end
  end

  assign sec_tick = !adj_s && running && (sec_pre == PW'(CLK_HZ - 1));
  assign adj_tick = adj_s && (adj_pre == PW'(CLK_HZ / 2 - 1));

  // sec_tick samples the pre-toggle running, so a coincident press never drops a tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b1;
      sec_pre <= '0;
      adj_pre <= '0;
    end else begin
      running <= running ^ press;
      if (adj_s || !running || sec_tick) sec_pre <= '0;
      else                               sec_pre <= sec_pre + PW'(1);
      if (!adj_s || adj_tick) adj_pre <= '0;
      else                    adj_pre <= adj_pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= '0;
    end else if (adj_tick) begin
      if (sel_s) {sec_tens, sec_ones} <= bcd_inc60({sec_tens, sec_ones});
      else       {min_tens, min_ones} <= bcd_inc60({min_tens, min_ones});
    end else if (sec_tick) begin
      {sec_tens, sec_ones} <= bcd_inc60({sec_tens, sec_ones});
      if ({sec_tens, sec_ones} == 8'h59)
        {min_tens, min_ones} <= bcd_inc60({min_tens, min_ones});
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic [PW-1:0] blink_pre;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_pre   <= '0;
      blink_phase <= 1'b0;
    end else if (!adj_s) begin
      blink_pre   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_pre == PW'(CLK_HZ / 4 - 1)) begin
      blink_pre   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_pre <= blink_pre + PW'(1);
    end
  end

  // Digit indices 0/1 are the seconds field, 2/3 the minutes field
  assign blank = adj_s && blink_phase && (sel_s ? !digit_idx[1] : digit_idx[1]);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cur_digit = sec_ones;
    case (digit_idx)
      AN_SEC_ONES: cur_digit = sec_ones;
      AN_SEC_TENS: cur_digit = sec_tens;
      AN_MIN_ONES: cur_digit = min_ones;
      AN_MIN_TENS: cur_digit = min_tens;
      default:     cur_digit = sec_ones;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= AN_SEC_ONES;
      an_q      <= 4'hF;
      seg_q     <= SEG_BLANK;
    end else begin
      if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      an_q  <= ~(4'b0001 << digit_idx);
      seg_q <= blank ? SEG_BLANK : seg_encode(cur_digit);
    end
  end

  assign pins.seg = seg_q;
  assign pins.an  = an_q;

endmodule

// File: tb/tb_stopwatch_top_level.sv
// tb_stopwatch_top_level: directed self-checking bench for the stopwatch at
// CLK_HZ=8, SCAN_CYCLES=2, DEBOUNCE_CYCLES=4; honours STOPWATCH_BLINK_EN.
module tb_stopwatch_top_level;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         edge_cnt = 0;
  logic [7:0] seg_table [10];

  stopwatch_if sw_if ();

  stopwatch_top_level #(
    .CLK_HZ          (8),
    .SCAN_CYCLES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (sw_if)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; drives the expected scan phase
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)", tag, observed, expected, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic adj, input logic sel, input logic pause);
    sw_if.adj   = adj;
    sw_if.sel   = sel;
    sw_if.pause = pause;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut(input logic adj, input logic sel);
    rst = 1'b0;
    applyStimulus(adj, sel, 1'b0);
    waitCycles(2);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] shownTime();
    return {dut.min_tens, dut.min_ones, dut.sec_tens, dut.sec_ones};
  endfunction

  function automatic logic [3:0] expectedAnode();
    int idx;
    idx = ((edge_cnt - 1) / 2) % 4;
    return ~(4'b0001 << idx);
  endfunction

  // Digits must be frozen while this runs: one full scan rotation of 8 edges
  task automatic checkScan(input logic [15:0] bcd);
    int         idx;
    logic [3:0] d;
    for (int i = 0; i < 8; i++) begin
      waitCycles(1);
      idx = ((edge_cnt - 1) / 2) % 4;
      d   = bcd[idx*4 +: 4];
      checkOutput("scan_an", sw_if.an, expectedAnode());
      checkOutput("scan_seg", sw_if.seg, seg_table[d]);
    end
  endtask

  initial begin
    int         blanks;
    int         idx;
    logic       is_blank;

    seg_table = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset, first increment on edge 8, pause/resume and a short glitch
    waitCycles(3);
    checkOutput("rst_an", sw_if.an, 4'hF);
    checkOutput("rst_seg", sw_if.seg, 8'hFF);
    rst = 1'b1;
    checkOutput("rel_time", shownTime(), 16'h0000);
    waitCycles(1);
    checkOutput("first_an", sw_if.an, 4'hE);
    checkOutput("first_seg", sw_if.seg, 8'hC0);
    waitCycles(6);
    checkOutput("edge7_time", shownTime(), 16'h0000);
    waitCycles(1);
    checkOutput("edge8_time", shownTime(), 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("paused_e18", shownTime(), 16'h0001);
    waitCycles(20);
    checkOutput("paused_e38", shownTime(), 16'h0001);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(4);
    checkOutput("resume_e60", shownTime(), 16'h0001);
    waitCycles(1);
    checkOutput("resume_e61", shownTime(), 16'h0002);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(15);
    checkOutput("glitch_e79", shownTime(), 16'h0004);

    // Preload 59:58 in adjust mode, then wrap to 00:00
    resetDut(1'b1, 1'b0);
    waitCycles(6);
    checkOutput("adjmin_e6", shownTime(), 16'h0100);
    waitCycles(3);
    checkOutput("adjmin_e9", shownTime(), 16'h0100);
    waitCycles(1);
    checkOutput("adjmin_e10", shownTime(), 16'h0200);
    waitCycles(228);
    checkOutput("preload_min", shownTime(), 16'h5900);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(232);
    checkOutput("preload_5958", shownTime(), 16'h5958);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(9);
    checkOutput("exit_e479", shownTime(), 16'h5958);
    waitCycles(1);
    checkOutput("wrap_5959", shownTime(), 16'h5959);
    waitCycles(7);
    checkOutput("hold_5959", shownTime(), 16'h5959);
    waitCycles(1);
    checkOutput("wrap_0000", shownTime(), 16'h0000);

    // Seconds adjust wraps without carry; then minutes adjust and display window
    resetDut(1'b1, 1'b1);
    waitCycles(234);
    checkOutput("adjsec_58", shownTime(), 16'h0058);
    waitCycles(4);
    checkOutput("adjsec_59", shownTime(), 16'h0059);
    waitCycles(4);
    checkOutput("adjsec_00", shownTime(), 16'h0000);
    waitCycles(4);
    checkOutput("adjsec_01", shownTime(), 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("adjmin_pre", shownTime(), 16'h0001);
    waitCycles(1);
    checkOutput("adjmin_post", shownTime(), 16'h0101);
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      waitCycles(1);
      idx = ((edge_cnt - 1) / 2) % 4;
      checkOutput("win_an", sw_if.an, expectedAnode());
      if (idx == 0)      checkOutput("win_sec_ones", sw_if.seg, seg_table[1]);
      else if (idx == 1) checkOutput("win_sec_tens", sw_if.seg, seg_table[0]);
      else if (sw_if.seg == 8'hFF) blanks++;
    end
    is_blank = (blanks > 0);
`ifdef STOPWATCH_BLINK_EN
    checkOutput("blink_seen", is_blank, 1'b1);
`else
    checkOutput("no_blank", is_blank, 1'b0);
`endif

    // Preload 12:34, pause, scan every digit, resume, then async reset mid-count
    resetDut(1'b1, 1'b0);
    waitCycles(50);
    checkOutput("pre12_min", shownTime(), 16'h1200);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(136);
    checkOutput("pre1234", shownTime(), 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(6);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(8);
    checkOutput("held1234", shownTime(), 16'h1234);
    checkScan(16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(6);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(8);
    checkOutput("resume_pre", shownTime(), 16'h1234);
    waitCycles(1);
    checkOutput("resume_1235", shownTime(), 16'h1235);
    waitCycles(3);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_an", sw_if.an, 4'hF);
    checkOutput("async_seg", sw_if.seg, 8'hFF);
    checkOutput("async_time", shownTime(), 16'h0000);
    waitCycles(1);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
